llc_arbiter: RTL
================

LLC_ARBITER -- requirements
Module: llc_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, request/response address width.
REQ-002 SHALL have parameter LINE_WIDTH, default 512, cacheline width in bits.
REQ-003 SHALL have ports clk_in input 1 (single clock) and rst_N_in input 1 (reset, asynchronous, active-low).
REQ-004 SHALL have port flush_in input 1: frontend misprediction flush; it cancels pending L1I read data.
REQ-005 SHALL have, for requester P in {l1i, l1d}: P_req_valid_in input 1; P_req_ready_out output 1; P_req_addr_in input ADDR_WIDTH; P_req_value_in input LINE_WIDTH; P_req_we_in input 1.
REQ-006 SHALL have, for P in {l1i, l1d}: P_resp_valid_out output 1; P_resp_ready_in input 1; P_resp_addr_out output ADDR_WIDTH; P_resp_value_out output LINE_WIDTH.
REQ-007 SHALL have LLC request ports: lc_valid_out output 1; lc_ready_in input 1; lc_addr_out output ADDR_WIDTH; lc_value_out output LINE_WIDTH; lc_we_out output 1.
REQ-008 SHALL have LLC response ports: lc_valid_in input 1; lc_ready_out output 1; lc_addr_in input ADDR_WIDTH; lc_value_in input LINE_WIDTH.

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT_RESP, DELIVER, with at most one outstanding LLC transaction.
REQ-010 In IDLE, SHALL grant one valid requester: sole valid wins; if both are valid, the one not granted last wins (round-robin pointer).
REQ-011 SHALL assert P_req_ready_out combinationally, only in IDLE, only to the granted requester.
REQ-012 On the IDLE accept edge, SHALL latch addr, value, we and owner, flip the pointer toward the other requester, and enter ISSUE.
REQ-013 In ISSUE, SHALL drive lc_valid_out=1 with the latched fields, held stable until lc_ready_in=1.
REQ-014 Each accepted request SHALL reach lc_valid_out exactly one cycle after acceptance.
REQ-015 On an ISSUE handshake with we=1, SHALL go to IDLE: writes complete on acceptance and produce no response.
REQ-016 On an ISSUE handshake with we=0, SHALL go to WAIT_RESP.
REQ-017 In WAIT_RESP, SHALL assert lc_ready_out=1; lc_ready_out is 0 in every other state.
REQ-018 On lc_valid_in and lc_ready_out, SHALL capture lc_addr_in and lc_value_in into the response buffer and enter DELIVER.
REQ-019 In DELIVER, SHALL drive the owner's resp_valid_out=1 with the buffered addr and value, held until resp_ready_in, then go to IDLE.
REQ-020 The non-owner's resp_valid_out SHALL be 0 at all times.
REQ-021 flush_in=1 in any cycle while owner=L1I and state is ISSUE, WAIT_RESP or DELIVER SHALL set a drop flag.
REQ-022 flush_in SHALL NOT abort an ISSUE handshake: lc_valid_out, once raised, is not retracted.
REQ-023 A dropped read SHALL still consume its LLC response in WAIT_RESP.
REQ-024 A dropped read SHALL suppress l1i_resp_valid_out in DELIVER and return to IDLE after one cycle.
REQ-025 With drop set, an L1I write SHALL complete normally (REQ-015).
REQ-026 flush_in SHALL have no effect on L1D-owned transactions or in IDLE.
REQ-027 The drop flag SHALL clear on return to IDLE.
REQ-028 lc_valid_in arriving outside WAIT_RESP SHALL be ignored (lc_ready_out=0).
REQ-029 A requester dropping valid before acceptance SHALL simply not be granted; no state changes.

Reset
REQ-030 On rst_N_in=0, SHALL asynchronously enter IDLE, set the pointer so L1D wins the first tie, and clear drop, owner and all latched fields.
REQ-031 During and after reset, until a grant: all *_valid_out=0, lc_ready_out=0, lc_we_out=0, all data/addr outputs=0.
REQ-032 Reset mid-transaction SHALL abandon the transaction with no replay.

Structure
REQ-033 The state enum (IDLE/ISSUE/WAIT_RESP/DELIVER) and the requester-id enum (REQ_L1I/REQ_L1D) SHALL live in a shared package alongside the existing op/uop packages.
REQ-034 Requester selection SHALL be a sub-module rr_arbiter2 (two requests, grant vector, pointer update on accept).

Verification
REQ-035 Reset then l1d read addr 0x1000 with lc_ready_in=1: lc_valid_out next cycle; LLC returns 0xAB..AB; l1d_resp_valid_out asserted with value 0xAB..AB; l1i sees nothing.
REQ-036 Both valid in IDLE from reset: L1D granted first, L1I second; repeat the tie: L1D granted again (alternating pattern).
REQ-037 l1d write addr 0x2040 we=1 with lc_ready_in held 0 for 3 cycles: lc fields stable for 4 cycles; after the handshake, IDLE with no response.
REQ-038 l1i read 0x400, flush_in pulsed in WAIT_RESP: LLC response consumed, l1i_resp_valid_out never 1, next request accepted 1 cycle later.
REQ-039 DELIVER with l1d_resp_ready_in=0 for 5 cycles: valid and data held; l1i request stalled until the handshake.
REQ-040 rst_N_in asserted in WAIT_RESP: outputs zero immediately (asynchronously); a later stray lc_valid_in is ignored.

Source files
------------

// File: rtl/llc_arbiter_pkg.sv
// Shared types for the L1I/L1D -> LLC request arbiter: FSM states and requester ids.
package llc_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        DELIVER   = 2'd3
    } state_t;

    typedef enum logic {
        REQ_L1I = 1'b0,
        REQ_L1D = 1'b1
    } req_id_t;

    localparam int NUM_REQ = 2;

    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ_L1I) ? REQ_L1D : REQ_L1I;
    endfunction

endpackage

// File: rtl/llc_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: a sole request wins, ties go to the side not granted last.
module rr_arbiter2
    import llc_arbiter_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_accept,
    output logic [NUM_REQ-1:0] o_grant,
    output req_id_t            o_winner
);

    req_id_t r_prio;

    always_comb begin
        o_grant = i_req;
        if (i_req[0] && i_req[1]) begin
            o_grant = (r_prio == REQ_L1D) ? 2'b10 : 2'b01;
        end
    end

    assign o_winner = o_grant[1] ? REQ_L1D : REQ_L1I;

    // Reset priority favours L1D so the first tie after reset goes to the data side.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_prio <= REQ_L1D;
        end else if (i_accept && (|o_grant)) begin
            r_prio <= other_req(o_winner);
        end
    end

endmodule

// File: rtl/llc_arbiter.sv
// Arbitrates L1I and L1D line requests onto a single LLC port, one transaction in flight.
//   state     | meaning
//   IDLE      | no transaction; grant one requester
//   ISSUE     | latched request presented on lc_*_out until lc_ready_in
//   WAIT_RESP | read issued; waiting for the LLC response
//   DELIVER   | buffered response presented to the owner (skipped if dropped)
module llc_arbiter
    import llc_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int LINE_WIDTH = 512
) (
    input  logic                  clk_in,
    input  logic                  rst_N_in,
    input  logic                  flush_in,

    input  logic                  l1i_req_valid_in,
    output logic                  l1i_req_ready_out,
    input  logic [ADDR_WIDTH-1:0] l1i_req_addr_in,
    input  logic [LINE_WIDTH-1:0] l1i_req_value_in,
    input  logic                  l1i_req_we_in,

    input  logic                  l1d_req_valid_in,
    output logic                  l1d_req_ready_out,
    input  logic [ADDR_WIDTH-1:0] l1d_req_addr_in,
    input  logic [LINE_WIDTH-1:0] l1d_req_value_in,
    input  logic                  l1d_req_we_in,

    output logic                  l1i_resp_valid_out,
    input  logic                  l1i_resp_ready_in,
    output logic [ADDR_WIDTH-1:0] l1i_resp_addr_out,
    output logic [LINE_WIDTH-1:0] l1i_resp_value_out,

    output logic                  l1d_resp_valid_out,
    input  logic                  l1d_resp_ready_in,
    output logic [ADDR_WIDTH-1:0] l1d_resp_addr_out,
    output logic [LINE_WIDTH-1:0] l1d_resp_value_out,

    output logic                  lc_valid_out,
    input  logic                  lc_ready_in,
    output logic [ADDR_WIDTH-1:0] lc_addr_out,
    output logic [LINE_WIDTH-1:0] lc_value_out,
    output logic                  lc_we_out,

    input  logic                  lc_valid_in,
    output logic                  lc_ready_out,
    input  logic [ADDR_WIDTH-1:0] lc_addr_in,
    input  logic [LINE_WIDTH-1:0] lc_value_in
);

    state_t                r_state;
    req_id_t               r_owner;
    logic                  r_drop;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_value;
    logic [ADDR_WIDTH-1:0] r_resp_addr;
    logic [LINE_WIDTH-1:0] r_resp_value;

    logic [NUM_REQ-1:0]    w_grant;
    req_id_t               w_winner;
    logic                  w_idle;
    logic                  w_accept;
    logic                  w_owner_ready;
    logic                  w_to_idle;
    logic                  w_flush_hit;
    logic                  w_show_resp;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle && (|w_grant);

    rr_arbiter2 u_rr_arbiter2 (
        .clk_in   (clk_in),
        .rst_n_in (rst_N_in),
        .i_req    ({l1d_req_valid_in, l1i_req_valid_in}),
        .i_accept (w_accept),
        .o_grant  (w_grant),
        .o_winner (w_winner)
    );

    assign l1i_req_ready_out = w_idle && w_grant[0];
    assign l1d_req_ready_out = w_idle && w_grant[1];

    assign w_owner_ready = (r_owner == REQ_L1D) ? l1d_resp_ready_in : l1i_resp_ready_in;
    assign w_flush_hit   = flush_in && (r_owner == REQ_L1I) && !w_idle;
    assign w_to_idle     = ((r_state == ISSUE) && lc_ready_in && r_we) ||
                           ((r_state == DELIVER) && (r_drop || w_owner_ready));

    assign lc_valid_out = (r_state == ISSUE);
    assign lc_addr_out  = r_addr;
    assign lc_value_out = r_value;
    assign lc_we_out    = r_we;
    assign lc_ready_out = (r_state == WAIT_RESP);

    // A dropped read spends its single DELIVER cycle with the response hidden.
    assign w_show_resp        = (r_state == DELIVER) && !r_drop;
    assign l1i_resp_valid_out = w_show_resp && (r_owner == REQ_L1I);
    assign l1d_resp_valid_out = w_show_resp && (r_owner == REQ_L1D);
    assign l1i_resp_addr_out  = r_resp_addr;
    assign l1i_resp_value_out = r_resp_value;
    assign l1d_resp_addr_out  = r_resp_addr;
    assign l1d_resp_value_out = r_resp_value;

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            r_state      <= IDLE;
            r_owner      <= REQ_L1I;
            r_drop       <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_value      <= '0;
            r_resp_addr  <= '0;
            r_resp_value <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_winner;
                        r_addr  <= (w_winner == REQ_L1D) ? l1d_req_addr_in  : l1i_req_addr_in;
                        r_value <= (w_winner == REQ_L1D) ? l1d_req_value_in : l1i_req_value_in;
                        r_we    <= (w_winner == REQ_L1D) ? l1d_req_we_in    : l1i_req_we_in;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (lc_ready_in) begin
                        r_state <= r_we ? IDLE : WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (lc_valid_in) begin
                        r_resp_addr  <= lc_addr_in;
                        r_resp_value <= lc_value_in;
                        r_state      <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (r_drop || w_owner_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_to_idle) begin
                r_drop <= 1'b0;
            end else if (w_flush_hit) begin
                r_drop <= 1'b1;
            end
        end
    end

endmodule
